// File: rtl/transmitter_pkg.sv
// transmitter_pkg: register map, bit positions, response codes and serializer states
package transmitter_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_BAUDDIV = 2'd3;
  localparam int CTRL_TX_EN = 0;
  localparam int CTRL_FIFO_CLR = 1;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_CNT_LSB = 4;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [15:0] MIN_DIV = 16'd4;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO with same-cycle read data, clear, and push-on-full accepted only alongside a pop
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = CW - 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // pointers and occupancy; clear wins over any push or pop in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  // storage
  always_ff @(posedge clk)
    if (do_push && !clr) mem[wp] <= din;
endmodule

// File: rtl/transmitter_axil.sv
// transmitter_axil: AXI4-Lite controlled UART transmitter with TX FIFO
module transmitter_axil #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DEFAULT_DIV = 868
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            TX,
  output logic                            TX_BUSY
);
  import transmitter_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic aw_ready, b_valid, ar_ready, r_valid, tx_en, ovf, tx;
  logic [31:0] r_data, rd_data, status;
  logic [15:0] div, div_wr, div_l, cnt;
  logic [7:0] shreg, fifo_dout;
  logic [2:0] bits;
  logic [1:0] wr_sel, rd_sel;
  logic [CW-1:0] count;
  logic wr_en, fifo_push, fifo_pop, fifo_clr, full, empty, frame_end, unused_ok;
  tx_state_t state;
  assign wr_en = aw_ready && S_AXI_AWVALID && S_AXI_WVALID;
  assign wr_sel = S_AXI_AWADDR[3:2];
  assign rd_sel = S_AXI_ARADDR[3:2];
  assign fifo_push = wr_en && wr_sel == REG_TXDATA && S_AXI_WSTRB[0];
  assign fifo_clr = wr_en && wr_sel == REG_CTRL && S_AXI_WSTRB[0] && S_AXI_WDATA[CTRL_FIFO_CLR];
  assign frame_end = cnt == div_l - 16'd1;
  assign fifo_pop = tx_en && !empty && (state == IDLE || (state == STOP && frame_end));
  assign div_wr = {S_AXI_WSTRB[1] ? S_AXI_WDATA[15:8] : div[15:8], S_AXI_WSTRB[0] ? S_AXI_WDATA[7:0] : div[7:0]};
  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY = aw_ready;
  assign S_AXI_BVALID = b_valid;
  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RVALID = r_valid;
  assign S_AXI_RRESP = RESP_OKAY;
  assign S_AXI_RDATA = C_S_AXI_DATA_WIDTH'(r_data);
  assign TX = tx;
  assign TX_BUSY = state != IDLE;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                       S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:16], S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:2]};
  tx_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk(ACLK), .rst(ARESET), .clr(fifo_clr), .push(fifo_push), .pop(fifo_pop),
    .din(S_AXI_WDATA[7:0]), .dout(fifo_dout), .full(full), .empty(empty), .count(count)
  );
  // status word assembly and read mux
  always_comb begin
    status = '0;
    status[ST_BUSY] = state != IDLE;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF] = ovf;
    status[ST_CNT_LSB +: 9] = 9'(count);
    rd_data = rd_sel == REG_CTRL ? {31'd0, tx_en} : rd_sel == REG_STATUS ? status :
              rd_sel == REG_BAUDDIV ? {16'd0, div} : '0;
  end
  // AXI-Lite handshakes and register file
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      aw_ready <= 1'b0;
      b_valid <= 1'b0;
      ar_ready <= 1'b0;
      r_valid <= 1'b0;
      r_data <= '0;
      tx_en <= 1'b0;
      ovf <= 1'b0;
      div <= 16'(DEFAULT_DIV);
    end else begin
      aw_ready <= !aw_ready && !b_valid && S_AXI_AWVALID && S_AXI_WVALID;
      b_valid <= wr_en || (b_valid && !S_AXI_BREADY);
      ar_ready <= !ar_ready && !r_valid && S_AXI_ARVALID;
      if (ar_ready && S_AXI_ARVALID) begin
        r_valid <= 1'b1;
        r_data <= rd_data;
      end else if (S_AXI_RREADY) r_valid <= 1'b0;
      if (wr_en && wr_sel == REG_CTRL && S_AXI_WSTRB[0]) tx_en <= S_AXI_WDATA[CTRL_TX_EN];
      ovf <= (ovf && !(wr_en && wr_sel == REG_STATUS && S_AXI_WSTRB[0] && S_AXI_WDATA[ST_OVF])) ||
             (fifo_push && full && !fifo_pop);
      if (wr_en && wr_sel == REG_BAUDDIV) div <= div_wr < MIN_DIV ? MIN_DIV : div_wr;
    end
  // serializer: each state lasts div_l cycles, a pop at STOP end chains straight into START
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state <= IDLE;
      tx <= 1'b1;
      shreg <= '0;
      div_l <= MIN_DIV;
      cnt <= '0;
      bits <= '0;
    end else if (fifo_pop) begin
      state <= START;
      tx <= 1'b0;
      shreg <= fifo_dout;
      div_l <= div;
      cnt <= '0;
    end else if (state != IDLE) begin
      cnt <= frame_end ? '0 : cnt + 16'd1;
      if (frame_end)
        case (state)
          START: begin
            state <= DATA;
            tx <= shreg[0];
            bits <= '0;
          end
          DATA: begin
            state <= bits == 3'd7 ? STOP : DATA;
            tx <= bits == 3'd7 ? 1'b1 : shreg[1];
            bits <= bits + 3'd1;
            shreg <= shreg >> 1;
          end
          default: begin
            state <= IDLE;
            tx <= 1'b1;
          end
        endcase
    end
endmodule

// File: tb/tb_transmitter_axil.sv
// tb_transmitter_axil: directed and randomized checks of the AXI-Lite UART transmitter against a queue model
module tb_transmitter_axil;
  import transmitter_pkg::*;
  localparam int DEPTH = 8;
  localparam int DEF_DIV = 868;
  logic ACLK = 1'b0, ARESET = 1'b1;
  logic [3:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic [2:0] S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
  logic S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_BREADY = 1'b1;
  logic S_AXI_ARVALID = 1'b0, S_AXI_RREADY = 1'b1;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0] S_AXI_WSTRB = 4'hF;
  logic S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, TX, TX_BUSY;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0] S_AXI_RDATA;
  int total = 0, passed = 0;
  logic [7:0] m_q[$];
  bit m_ovf = 1'b0;
  int m_div = DEF_DIV;
  always #5 ACLK = ~ACLK;
  transmitter_axil #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .TX(TX), .TX_BUSY(TX_BUSY)
  );
  function automatic logic [3:0] addr(input logic [1:0] r);
    return {r, 2'b00};
  endfunction
  function automatic logic [31:0] exp_status();
    int s = m_q.size();
    return 32'(s * 16 + (m_ovf ? 8 : 0) + (s == 0 ? 4 : 0) + (s == DEPTH ? 2 : 0));
  endfunction
  function automatic void m_push(input logic [7:0] b);
    if (m_q.size() < DEPTH) m_q.push_back(b);
    else m_ovf = 1'b1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask
  task automatic axi_write(input logic [1:0] r, input logic [31:0] d);
    int n = 0;
    S_AXI_AWADDR = addr(r);
    S_AXI_WDATA = d;
    S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID = 1'b1;
    do begin step(); n++; end while (!S_AXI_AWREADY && n < 20);
    chk("awready", S_AXI_AWREADY, 1);
    chk("wready", S_AXI_WREADY, 1);
    step();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID = 1'b0;
    chk("bvalid", S_AXI_BVALID, 1);
    chk("bresp", S_AXI_BRESP, RESP_OKAY);
    step();
  endtask
  task automatic rd_chk(input string tag, input logic [1:0] r, input logic [31:0] exp);
    int n = 0;
    S_AXI_ARADDR = addr(r);
    S_AXI_ARVALID = 1'b1;
    do begin step(); n++; end while (!S_AXI_ARREADY && n < 20);
    chk("arready", S_AXI_ARREADY, 1);
    step();
    S_AXI_ARVALID = 1'b0;
    chk("rvalid", S_AXI_RVALID, 1);
    chk("rresp", S_AXI_RRESP, RESP_OKAY);
    chk(tag, S_AXI_RDATA, exp);
    step();
  endtask
  task automatic push_rand();
    logic [7:0] b = 8'($urandom);
    axi_write(REG_TXDATA, {24'd0, b});
    m_push(b);
  endtask
  task automatic run_frames(input int n, input int d0, input int d1);
    int w = 0;
    while (TX !== 1'b0 && w < 100) begin step(); w++; end
    chk("frame_start", TX, 0);
    for (int f = 0; f < n; f++) begin
      logic [7:0] b;
      int d;
      b = m_q.pop_front();
      d = f == 0 ? d0 : d1;
      for (int k = 0; k < 10; k++) begin
        logic bv;
        bv = k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
        for (int c = 0; c < d; c++) begin
          chk($sformatf("tx f%0d b%0d c%0d", f, k, c), TX, bv);
          chk($sformatf("busy f%0d b%0d", f, k), TX_BUSY, 1);
          step();
        end
      end
    end
    chk("idle_tx", TX, 1);
    chk("idle_busy", TX_BUSY, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int d, awp, wp;
    repeat (3) step();
    chk("rst_tx", TX, 1);
    chk("rst_busy", TX_BUSY, 0);
    chk("rst_awready", S_AXI_AWREADY, 0);
    chk("rst_wready", S_AXI_WREADY, 0);
    chk("rst_bvalid", S_AXI_BVALID, 0);
    chk("rst_arready", S_AXI_ARREADY, 0);
    chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    ARESET = 1'b0;
    step();
    rd_chk("ctrl_rst", REG_CTRL, 0);
    rd_chk("status_rst", REG_STATUS, exp_status());
    rd_chk("txdata_rst", REG_TXDATA, 0);
    rd_chk("bauddiv_rst", REG_BAUDDIV, 32'(m_div));
    axi_write(REG_BAUDDIV, 4);
    m_div = 4;
    axi_write(REG_CTRL, 1);
    axi_write(REG_TXDATA, 32'hA5);
    m_q.push_back(8'hA5);
    run_frames(1, 4, 4);
    axi_write(REG_BAUDDIV, 1);
    rd_chk("div_clamp1", REG_BAUDDIV, 4);
    axi_write(REG_BAUDDIV, 0);
    rd_chk("div_clamp0", REG_BAUDDIV, 4);
    axi_write(REG_BAUDDIV, 7);
    rd_chk("div_7", REG_BAUDDIV, 7);
    axi_write(REG_CTRL, 0);
    for (int i = 0; i < 9; i++) push_rand();
    rd_chk("status_ovf", REG_STATUS, exp_status());
    axi_write(REG_STATUS, 8);
    m_ovf = 1'b0;
    rd_chk("status_ovf_clr", REG_STATUS, exp_status());
    axi_write(REG_CTRL, 2);
    m_q.delete();
    rd_chk("status_fifo_clr", REG_STATUS, exp_status());
    rd_chk("ctrl_clr_reads0", REG_CTRL, 0);
    d = $urandom_range(4, 6);
    axi_write(REG_BAUDDIV, 32'(d));
    for (int i = 0; i < 3; i++) push_rand();
    axi_write(REG_CTRL, 1);
    run_frames(3, d, d);
    rd_chk("ctrl_en", REG_CTRL, 1);
    axi_write(REG_CTRL, 0);
    axi_write(REG_BAUDDIV, 4);
    for (int i = 0; i < 2; i++) push_rand();
    axi_write(REG_CTRL, 1);
    fork
      run_frames(2, 4, 6);
      begin repeat (8) step(); axi_write(REG_BAUDDIV, 6); end
    join
    axi_write(REG_CTRL, 0);
    axi_write(REG_BAUDDIV, 4);
    for (int i = 0; i < 3; i++) push_rand();
    axi_write(REG_CTRL, 1);
    fork
      run_frames(1, 4, 4);
      begin repeat (5) step(); axi_write(REG_CTRL, 0); end
    join
    repeat (10) step();
    chk("en_off_idle", TX, 1);
    rd_chk("status_en_off", REG_STATUS, exp_status());
    axi_write(REG_CTRL, 1);
    fork
      run_frames(1, 4, 4);
      begin repeat (5) step(); axi_write(REG_CTRL, 3); m_q.delete(); end
    join
    rd_chk("status_clr_mid", REG_STATUS, exp_status());
    axi_write(REG_CTRL, 0);
    for (int i = 0; i < 3; i++) push_rand();
    axi_write(REG_CTRL, 1);
    repeat (7) step();
    chk("pre_rst_busy", TX_BUSY, 1);
    ARESET = 1'b1;
    #1;
    chk("async_rst_tx", TX, 1);
    chk("async_rst_busy", TX_BUSY, 0);
    repeat (2) step();
    ARESET = 1'b0;
    m_q.delete();
    m_ovf = 1'b0;
    m_div = DEF_DIV;
    step();
    rd_chk("status_after_rst", REG_STATUS, exp_status());
    rd_chk("div_after_rst", REG_BAUDDIV, 32'(m_div));
    S_AXI_AWADDR = addr(REG_BAUDDIV);
    S_AXI_WDATA = 32'h20;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); chk("aw_early", S_AXI_AWREADY, 0); end
    S_AXI_WVALID = 1'b1;
    awp = 0;
    wp = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (S_AXI_AWREADY) awp++;
      if (S_AXI_WREADY) wp++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID = 1'b0;
    chk("aw_pulses", 32'(awp), 1);
    chk("w_pulses", 32'(wp), 1);
    chk("bvalid_hold", S_AXI_BVALID, 1);
    S_AXI_BREADY = 1'b1;
    step();
    chk("bvalid_drop", S_AXI_BVALID, 0);
    rd_chk("div_once", REG_BAUDDIV, 32'h20);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
